mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 50 +++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding and
// the captured bus transaction.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INSTR_REQ  = 3'd1,
    INSTR_WAIT = 3'd2,
    DATA_REQ   = 3'd3,
    DATA_WAIT  = 3'd4
  } arb_state_t;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } bus_source_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byte_enable;
    logic        write;
    bus_source_t source;
  } bus_transaction_t;

  localparam logic [3:0] READ_BYTE_ENABLE = 4'hF;

  // Reads always present full byte lanes and a zero write payload on the bus.
  function automatic bus_transaction_t make_read(input logic [31:0] addr, input bus_source_t src);
    bus_transaction_t t;
    t.address     = addr;
    t.data        = 32'h0000_0000;
    t.byte_enable = READ_BYTE_ENABLE;
    t.write       = 1'b0;
    t.source      = src;
    return t;
  endfunction

  function automatic bus_transaction_t make_write(input logic [31:0] addr, input logic [31:0] wdata,
                                                  input logic [3:0] be);
    bus_transaction_t t;
    t.address     = addr;
    t.data        = wdata;
    t.byte_enable = be;
    t.write       = 1'b1;
    t.source      = SRC_DATA;
    return t;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-outstanding bus,
// favouring data traffic but bounding how long a pending fetch can be starved.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instructionAddress,
  input  logic        instructionRequest,
  output logic [31:0] instructionData,
  output logic        instructionDataValid,
  input  logic [31:0] dataAddress,
  input  logic        dataReadRequest,
  input  logic        dataWriteRequest,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  output logic [3:0]  busByteEnable,
  output logic        busWrite,
  output logic        busRequest,
  input  logic        busReady,
  input  logic [31:0] busReadData,
  input  logic        busReadValid
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t       state, state_next;
  logic [CW-1:0]    starve_count, starve_next;
  bus_transaction_t txn, txn_next;
  logic             flush, flush_next, flush_now;
  logic             bus_request, bus_request_next;
  logic [31:0]      instr_data_next, load_data_next;
  logic             instr_valid_next, load_valid_next, store_complete_next;
  logic             data_pending, starve_at_limit, instr_grant, data_grant;

  assign data_pending    = dataReadRequest | dataWriteRequest;
  assign starve_at_limit = (starve_count == CW'(STARVE_LIMIT));
  assign instr_grant     = instructionRequest & (~data_pending | starve_at_limit);
  assign data_grant      = data_pending & ~instr_grant;

  assign busAddress    = txn.address;
  assign busWriteData  = txn.data;
  assign busByteEnable = txn.byte_enable;
  assign busWrite      = txn.write;
  assign busRequest    = bus_request;

  // Grant decision, bus handshake and response routing.
  always_comb begin
    state_next          = state;
    starve_next         = starve_count;
    txn_next            = txn;
    flush_next          = flush;
    bus_request_next    = bus_request;
    instr_data_next     = instructionData;
    load_data_next      = loadData;
    instr_valid_next    = 1'b0;
    load_valid_next     = 1'b0;
    store_complete_next = 1'b0;
    // A fetch whose address moved or whose request dropped is stale once it returns.
    flush_now = flush | ((state == INSTR_WAIT) &
                         ((instructionAddress != txn.address) | ~instructionRequest));

    case (state)
      IDLE: begin
        if (instr_grant) begin
          state_next       = INSTR_REQ;
          txn_next         = make_read(instructionAddress, SRC_INSTR);
          starve_next      = '0;
          bus_request_next = 1'b1;
          flush_next       = 1'b0;
        end else if (data_grant) begin
          state_next       = DATA_REQ;
          bus_request_next = 1'b1;
          flush_next       = 1'b0;
          if (dataWriteRequest) begin
            txn_next = make_write(dataAddress, storeData, byteEnable);
          end else begin
            txn_next = make_read(dataAddress, SRC_DATA);
          end
          if (instructionRequest && !starve_at_limit) begin
            starve_next = starve_count + CW'(1);
          end else begin
            starve_next = starve_count;
          end
        end else begin
          state_next = IDLE;
        end
      end
      INSTR_REQ: begin
        if (busReady) begin
          state_next       = INSTR_WAIT;
          bus_request_next = 1'b0;
        end else begin
          state_next = INSTR_REQ;
        end
      end
      DATA_REQ: begin
        if (busReady) begin
          bus_request_next = 1'b0;
          if (txn.write) begin
            state_next          = IDLE;
            store_complete_next = 1'b1;
          end else begin
            state_next = DATA_WAIT;
          end
        end else begin
          state_next = DATA_REQ;
        end
      end
      INSTR_WAIT, DATA_WAIT: begin
        if (busReadValid) begin
          state_next = IDLE;
          flush_next = 1'b0;
          if (txn.source == SRC_DATA) begin
            load_data_next  = busReadData;
            load_valid_next = 1'b1;
          end else if (!flush_now) begin
            instr_data_next  = busReadData;
            instr_valid_next = 1'b1;
          end else begin
            instr_data_next = instructionData;
          end
        end else begin
          flush_next = flush_now;
        end
      end
      default: begin
        state_next       = IDLE;
        bus_request_next = 1'b0;
        flush_next       = 1'b0;
      end
    endcase
  end

  // All arbiter state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      starve_count         <= '0;
      txn                  <= '0;
      flush                <= 1'b0;
      bus_request          <= 1'b0;
      instructionData      <= 32'h0000_0000;
      instructionDataValid <= 1'b0;
      loadData             <= 32'h0000_0000;
      loadDataValid        <= 1'b0;
      storeComplete        <= 1'b0;
    end else begin
      state                <= state_next;
      starve_count         <= starve_next;
      txn                  <= txn_next;
      flush                <= flush_next;
      bus_request          <= bus_request_next;
      instructionData      <= instr_data_next;
      instructionDataValid <= instr_valid_next;
      loadData             <= load_data_next;
      loadDataValid        <= load_valid_next;
      storeComplete        <= store_complete_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, stalled store, starvation bound,
// fetch flush, reset mid-transaction and write-before-read ordering.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instructionAddress = 32'h0;
  logic        instructionRequest = 1'b0;
  logic [31:0] instructionData;
  logic        instructionDataValid;
  logic [31:0] dataAddress = 32'h0;
  logic        dataReadRequest = 1'b0;
  logic        dataWriteRequest = 1'b0;
  logic [31:0] storeData = 32'h0;
  logic [3:0]  byteEnable = 4'h0;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic [3:0]  busByteEnable;
  logic        busWrite;
  logic        busRequest;
  logic        busReady = 1'b0;
  logic [31:0] busReadData = 32'h0;
  logic        busReadValid = 1'b0;

  int total  = 0;
  int passed = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .instructionAddress(instructionAddress), .instructionRequest(instructionRequest),
    .instructionData(instructionData), .instructionDataValid(instructionDataValid),
    .dataAddress(dataAddress), .dataReadRequest(dataReadRequest),
    .dataWriteRequest(dataWriteRequest), .storeData(storeData), .byteEnable(byteEnable),
    .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete),
    .busAddress(busAddress), .busWriteData(busWriteData), .busByteEnable(busByteEnable),
    .busWrite(busWrite), .busRequest(busRequest), .busReady(busReady),
    .busReadData(busReadData), .busReadValid(busReadValid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int grants, load_pulses, instr_pulses, both;

    // Reset state
    step();
    step();
    check("rst_busRequest", busRequest, 32'h0);
    check("rst_busAddress", busAddress, 32'h0);
    check("rst_busByteEnable", busByteEnable, 32'h0);
    check("rst_instrValid", instructionDataValid, 32'h0);
    check("rst_storeComplete", storeComplete, 32'h0);

    // Fetch 0x100: grant on first edge after release, valid three cycles later
    reset = 1'b1;
    instructionAddress = 32'h100;
    instructionRequest = 1'b1;
    busReady = 1'b1;
    step();
    check("fetch_busRequest", busRequest, 32'h1);
    check("fetch_busAddress", busAddress, 32'h100);
    check("fetch_busWrite", busWrite, 32'h0);
    check("fetch_busByteEnable", busByteEnable, 32'hF);
    check("fetch_busWriteData", busWriteData, 32'h0);
    step();
    check("fetch_wait_busRequest", busRequest, 32'h0);
    busReadValid = 1'b1;
    busReadData = 32'h0050_0093;
    step();
    check("fetch_valid", instructionDataValid, 32'h1);
    check("fetch_data", instructionData, 32'h0050_0093);
    check("fetch_no_load", loadDataValid, 32'h0);
    instructionRequest = 1'b0;
    busReadValid = 1'b0;
    step();
    check("fetch_pulse_end", instructionDataValid, 32'h0);
    check("fetch_data_hold", instructionData, 32'h0050_0093);
    check("fetch_idle", busRequest, 32'h0);

    // Store with busReady low for three cycles
    dataWriteRequest = 1'b1;
    dataAddress = 32'h2004;
    storeData = 32'hDEAD_BEEF;
    byteEnable = 4'b0011;
    busReady = 1'b0;
    step();
    check("store_busWrite", busWrite, 32'h1);
    check("store_busAddress", busAddress, 32'h2004);
    check("store_busWriteData", busWriteData, 32'hDEAD_BEEF);
    check("store_busByteEnable", busByteEnable, 32'h3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("store_hold%0d", i), busRequest, 32'h1);
      check($sformatf("store_early%0d", i), storeComplete, 32'h0);
      if (i == 3) busReady = 1'b1;
      step();
    end
    check("store_released", busRequest, 32'h0);
    check("store_complete", storeComplete, 32'h1);
    dataWriteRequest = 1'b0;
    busReady = 1'b0;
    step();
    check("store_complete_once", storeComplete, 32'h0);

    // Starvation bound: both ports held, pattern D D D D I D D D D I
    dataReadRequest = 1'b1;
    dataAddress = 32'h3000;
    instructionRequest = 1'b1;
    instructionAddress = 32'h400;
    busReady = 1'b1;
    busReadValid = 1'b1;
    busReadData = 32'hCAFE_0001;
    grants = 0;
    load_pulses = 0;
    instr_pulses = 0;
    both = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      step();
      if (loadDataValid) load_pulses++;
      if (instructionDataValid) instr_pulses++;
      if (loadDataValid && instructionDataValid) both++;
      if (busRequest) begin
        check($sformatf("starve_grant%0d", grants), busAddress,
              (grants % 5 == 4) ? 32'h400 : 32'h3000);
        grants++;
      end
    end
    check("starve_grant_count", grants, 32'd10);
    check("starve_load_pulses", load_pulses, 32'd8);
    check("starve_instr_pulses", instr_pulses, 32'd1);
    check("starve_no_overlap", both, 32'd0);
    dataReadRequest = 1'b0;
    instructionRequest = 1'b0;
    step();
    step();
    check("starve_dropped_fetch", instructionDataValid, 32'h0);
    busReadValid = 1'b0;
    step();
    check("starve_idle", busRequest, 32'h0);

    // Flush: fetch address moves while waiting for the response
    instructionAddress = 32'h100;
    instructionRequest = 1'b1;
    step();
    check("flush_busAddress0", busAddress, 32'h100);
    step();
    instructionAddress = 32'h200;
    step();
    busReadValid = 1'b1;
    busReadData = 32'h1111_1111;
    step();
    check("flush_suppressed", instructionDataValid, 32'h0);
    check("flush_data_hold", instructionData, 32'hCAFE_0001);
    busReadValid = 1'b0;
    step();
    check("flush_refetch_req", busRequest, 32'h1);
    check("flush_refetch_addr", busAddress, 32'h200);
    step();
    busReadValid = 1'b1;
    busReadData = 32'h2222_2222;
    step();
    check("flush_refetch_valid", instructionDataValid, 32'h1);
    check("flush_refetch_data", instructionData, 32'h2222_2222);
    instructionRequest = 1'b0;
    busReadValid = 1'b0;
    step();

    // Reset while a load waits for its response
    dataReadRequest = 1'b1;
    dataAddress = 32'h5000;
    step();
    check("rstmid_busAddress", busAddress, 32'h5000);
    step();
    reset = 1'b0;
    dataReadRequest = 1'b0;
    #1;
    check("rstmid_loadData", loadData, 32'h0);
    check("rstmid_instrData", instructionData, 32'h0);
    check("rstmid_busAddress_clr", busAddress, 32'h0);
    step();
    reset = 1'b1;
    busReadValid = 1'b1;
    busReadData = 32'h3333_3333;
    step();
    check("rstmid_late_valid0", loadDataValid, 32'h0);
    step();
    check("rstmid_late_valid1", loadDataValid, 32'h0);
    check("rstmid_loadData_kept", loadData, 32'h0);
    busReadValid = 1'b0;
    instructionAddress = 32'h600;
    instructionRequest = 1'b1;
    step();
    check("rstmid_idle_grant", busRequest, 32'h1);
    check("rstmid_idle_addr", busAddress, 32'h600);
    step();
    busReadValid = 1'b1;
    busReadData = 32'h6666_6666;
    step();
    check("rstmid_fetch_data", instructionData, 32'h6666_6666);
    instructionRequest = 1'b0;
    busReadValid = 1'b0;
    step();

    // Simultaneous read and write to 0x3000: write first, then read
    dataReadRequest = 1'b1;
    dataWriteRequest = 1'b1;
    dataAddress = 32'h3000;
    storeData = 32'h0000_ABCD;
    byteEnable = 4'hF;
    step();
    check("rw_first_write", busWrite, 32'h1);
    check("rw_first_wdata", busWriteData, 32'h0000_ABCD);
    step();
    check("rw_store_complete", storeComplete, 32'h1);
    check("rw_no_load_yet", loadDataValid, 32'h0);
    dataWriteRequest = 1'b0;
    step();
    check("rw_read_req", busRequest, 32'h1);
    check("rw_read_write_flag", busWrite, 32'h0);
    check("rw_read_wdata", busWriteData, 32'h0);
    check("rw_read_addr", busAddress, 32'h3000);
    step();
    busReadValid = 1'b1;
    busReadData = 32'h4444_4444;
    step();
    check("rw_load_valid", loadDataValid, 32'h1);
    check("rw_load_data", loadData, 32'h4444_4444);
    dataReadRequest = 1'b0;
    busReadValid = 1'b0;
    step();
    check("rw_load_pulse_end", loadDataValid, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
